inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
//
// Instruction fetch controller. Issues one instruction-memory request at a
// time for the current PC. It captures the returned word and presents it to
// the instruction field parser with a valid/ready handshake. After each
// handshake it advances the PC by 4. A branch/jump redirect replaces the PC at
// any time. A redirect drops any instruction that is in flight or being
// presented.
//
// Optional feature (macro FETCH_HALT_ON_ZERO_EN):
//   When defined, a handshake on an all-zero instruction parks the block in
//   HALT. Only reset leaves HALT. The extra output `halted` exists only in
//   this build.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   start        in   begin fetching from the current PC (IDLE only)
//   imem_req     out  memory request, high exactly while waiting for memory
//   imem_addr    out  request address, always equal to the current PC
//   imem_ack     in   memory acknowledge (honoured only while requesting)
//   imem_rdata   in   memory read data, qualified by imem_ack
//   inst         out  instruction presented to the parser
//   inst_valid   out  inst/pc_out are valid
//   inst_ready   in   parser accepts inst
//   pc_out       out  PC of the presented instruction
//   redirect     in   branch/jump redirect
//   redirect_pc  in   redirect target
//   fetch_count  out  number of instructions consumed (wraps at 2^32)
//   halted       out  high in HALT (FETCH_HALT_ON_ZERO_EN builds only)
// -----------------------------------------------------------------------------
module inst_fetch_ctrl #(
  parameter int unsigned             ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       fetch_count
`ifdef FETCH_HALT_ON_ZERO_EN
  ,
  output logic              halted
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
`ifdef FETCH_HALT_ON_ZERO_EN
    ,
    S_HALT  = 2'd3
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case. Otherwise a path that
    // does not assign it would infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    pc_out_d      = pc_out_q;
    inst_d        = inst_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      S_IDLE: begin
        // A redirect retargets the PC in IDLE. With start in the same cycle,
        // the first fetch goes to the new target.
        if (redirect) pc_d = redirect_pc;
        if (start)    state_d = S_REQ;
      end

      S_REQ: begin
        if (redirect) begin
          // A coincident ack carries data for the old PC, so it is discarded.
          pc_d = redirect_pc;
        end else if (imem_ack) begin
          inst_d   = imem_rdata;
          pc_out_d = pc_q;
          state_d  = S_VALID;
        end
      end

      S_VALID: begin
        if (redirect) begin
          // The redirect wins over a coincident ready. The presented
          // instruction is dropped and is not counted.
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (inst_ready) begin
          fetch_count_d = fetch_count_q + 32'd1;
`ifdef FETCH_HALT_ON_ZERO_EN
          if (inst_q == 32'h0) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + ADDR_W'(4);
            state_d = S_REQ;
          end
`else
          pc_d    = pc_q + ADDR_W'(4);
          state_d = S_REQ;
`endif
        end
      end

`ifdef FETCH_HALT_ON_ZERO_EN
      S_HALT: begin
        // Sticky until reset. start and redirect are deliberately ignored.
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make all flops update together from
    // values sampled before the edge, matching the hardware.
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      pc_out_q      <= RESET_PC;
      inst_q        <= 32'h0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_out_q      <= pc_out_d;
      inst_q        <= inst_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all of them come straight from flops.
  // ---------------------------------------------------------------------------
  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign inst_valid  = (state_q == S_VALID);
  assign inst        = inst_q;
  assign pc_out      = pc_out_q;
  assign fetch_count = fetch_count_q;
`ifdef FETCH_HALT_ON_ZERO_EN
  assign halted      = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
//
// Directed bench for inst_fetch_ctrl. A behavioural model tracks the fetch
// phase and the architectural values: PC, presented instruction and its PC,
// and consumed count. It updates on each rising edge from the same inputs as
// the DUT. A compare process checks every DUT output against the model on each
// falling edge. Hand-computed literal checks in the stimulus pin the model.
// Honours FETCH_HALT_ON_ZERO_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

  localparam int unsigned       ADDR_W   = 64;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  logic              clk = 1'b0;
  logic              reset, start, imem_ack, inst_ready, redirect;
  logic [31:0]       imem_rdata;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req, inst_valid;
  logic [ADDR_W-1:0] imem_addr, pc_out;
  logic [31:0]       inst, fetch_count;
`ifdef FETCH_HALT_ON_ZERO_EN
  logic              halted;
`endif

  inst_fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .pc_out      (pc_out),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_count (fetch_count)
`ifdef FETCH_HALT_ON_ZERO_EN
    ,
    .halted      (halted)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_PRESENT = 2, PH_HALTED = 3;

`ifdef FETCH_HALT_ON_ZERO_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  int                m_phase = PH_IDLE;
  logic [ADDR_W-1:0] m_pc = RESET_PC, m_pc_out = RESET_PC;
  logic [31:0]       m_inst = '0, m_count = '0;
  bit                chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = PH_IDLE; m_pc = RESET_PC; m_pc_out = RESET_PC;
      m_inst = 32'h0; m_count = 32'h0;
    end else if (m_phase == PH_IDLE) begin
      if (redirect) m_pc = redirect_pc;
      if (start) m_phase = PH_FETCH;
    end else if (m_phase == PH_FETCH) begin
      if (redirect) m_pc = redirect_pc;
      else if (imem_ack) begin
        m_inst = imem_rdata; m_pc_out = m_pc; m_phase = PH_PRESENT;
      end
    end else if (m_phase == PH_PRESENT) begin
      if (redirect) begin
        m_pc = redirect_pc; m_phase = PH_FETCH;
      end else if (inst_ready) begin
        m_count = m_count + 1;
        if (HALT_EN && m_inst == 32'h0) m_phase = PH_HALTED;
        else begin
          m_pc = m_pc + 4; m_phase = PH_FETCH;
        end
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req",    64'(imem_req),    64'(m_phase == PH_FETCH));
      check("inst_valid",  64'(inst_valid),  64'(m_phase == PH_PRESENT));
      check("imem_addr",   imem_addr,        m_pc);
      check("inst",        64'(inst),        64'(m_inst));
      check("pc_out",      pc_out,           m_pc_out);
      check("fetch_count", 64'(fetch_count), 64'(m_count));
`ifdef FETCH_HALT_ON_ZERO_EN
      check("halted",      64'(halted),      64'(m_phase == PH_HALTED));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; start = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0; imem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    reset  = 1'b0;
    tick();

    // Reset state
    check("rst_req",   64'(imem_req),    64'd0);
    check("rst_valid", 64'(inst_valid),  64'd0);
    check("rst_count", 64'(fetch_count), 64'd0);
    check("rst_addr",  imem_addr,        64'h0);
    check("rst_inst",  64'(inst),        64'h0);

    // Scenario 1: start, ack in the first REQ cycle, ready held high
    start = 1'b1;
    tick();                                   // now in REQ
    start = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF; inst_ready = 1'b1;
    tick();                                   // now in VALID, 2 cycles after start
    check("s1_inst",   64'(inst),       64'h0000_0000_FFFF_FFFF);
    check("s1_pc_out", pc_out,          64'h0);
    check("s1_valid",  64'(inst_valid), 64'd1);
    imem_ack = 1'b0;
    tick();                                   // handshake taken
    check("s1_addr",  imem_addr,         64'h4);
    check("s1_count", 64'(fetch_count),  64'd1);
    check("s1_req",   64'(imem_req),     64'd1);

    // Scenario 2: hold ready low for 5 cycles
    inst_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hAAAA_AAAA;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("s2_inst",  64'(inst),        64'h0000_0000_AAAA_AAAA);
      check("s2_pcout", pc_out,           64'h4);
      check("s2_valid", 64'(inst_valid),  64'd1);
      check("s2_count", 64'(fetch_count), 64'd1);
      check("s2_req",   64'(imem_req),    64'd0);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("s2_addr_after", imem_addr,        64'h8);
    check("s2_count_after", 64'(fetch_count), 64'd2);

    // Scenario 3: redirect coincident with ack discards the data
    redirect = 1'b1; redirect_pc = 64'h100; imem_ack = 1'b1; imem_rdata = 32'h007F_E007;
    tick();
    redirect = 1'b0;
    check("s3_addr", imem_addr,     64'h100);
    check("s3_req",  64'(imem_req), 64'd1);
    check("s3_inst", 64'(inst),     64'h0000_0000_AAAA_AAAA);
    imem_rdata = 32'h1357_9BDF;               // ack still high: accepted at 0x100
    tick();
    imem_ack = 1'b0;
    check("s3_pcout", pc_out, 64'h100);
    // A redirect in VALID with ready high is not a handshake.
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; inst_ready = 1'b1;
    tick();
    redirect = 1'b0; inst_ready = 1'b0;
    check("s3_count_kept", 64'(fetch_count), 64'd2);
    check("s3_addr_top",   imem_addr,        64'hFFFF_FFFF_FFFF_FFFC);

    // Scenario 4: PC and count wrap together on one handshake
    #1;
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0; inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("s4_pc_wrap",    imem_addr,        64'h0);
    check("s4_count_wrap", 64'(fetch_count), 64'd0);

    // Scenario 5: handshake on a zero instruction
    imem_ack = 1'b1; imem_rdata = 32'h0;
    tick();
    imem_ack = 1'b0; inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("s5_count", 64'(fetch_count), 64'd1);
`ifdef FETCH_HALT_ON_ZERO_EN
    check("s5_halted", 64'(halted),   64'd1);
    check("s5_req",    64'(imem_req), 64'd0);
    start = 1'b1; redirect = 1'b1; redirect_pc = 64'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s5_halt_sticky", 64'(halted), 64'd1);
      check("s5_halt_pc",     imem_addr,   64'h0);
    end
    do_reset();
    tick();
    check("s5_reset_exit", 64'(halted), 64'd0);
`else
    check("s5_req", 64'(imem_req), 64'd1);
    check("s5_pc4", imem_addr,     64'h4);
    do_reset();
    tick();
`endif

    // Redirect in IDLE retargets without starting.
    redirect = 1'b1; redirect_pc = 64'h40;
    tick();
    redirect = 1'b0;
    check("idle_redir_addr", imem_addr,     64'h40);
    check("idle_redir_req",  64'(imem_req), 64'd0);

    // Scenario 6: reset during VALID with ready high
    start = 1'b1;
    tick();
    start = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1111_1111; inst_ready = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();                                   // handshake: count 1, pc 0x44
    check("s6_count_pre", 64'(fetch_count), 64'd1);
    inst_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    tick();                                   // VALID at 0x44
    check("s6_pcout", pc_out, 64'h44);
    reset = 1'b1; inst_ready = 1'b1; imem_ack = 1'b1;
    tick();
    idle_inputs();
    check("s6_count", 64'(fetch_count), 64'd0);
    check("s6_valid", 64'(inst_valid),  64'd0);
    check("s6_pc",    imem_addr,        RESET_PC);
    check("s6_inst",  64'(inst),        64'h0);
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
